jesd204b_descrambler_mlane: RTL
===============================

// Module: jesd204b_descrambler_mlane
// PURPOSE
//  Multi-lane JESD204B self-synchronising descrambler, polynomial 1+x^14+x^15.
//  Parametrised successor to the single-lane descrambler, with independent per-lane LFSR state.
//  Adds a valid handshake, registered output, runtime bypass and per-lane lock status.
//  Sits between the lane deframer/8b10b alignment output and the transport-layer de-mapper.
// PARAMETERS
//  LANES       4   number of independent lanes (1..8)
//  DATA_WIDTH  32  bits per lane per cycle; multiple of 8, >=16
// PORTS
//  clk        in   1                 rising-edge clock
//  reset      in   1                 asynchronous, active-low reset
//  bypass     in   1                 1: pass data unmodified, LFSR still tracks input
//  in_valid   in   1                 input word valid on all lanes this cycle
//  in         in   LANES*DATA_WIDTH  scrambled data; lane k = in[k*DATA_WIDTH +: DATA_WIDTH]
//  out        out  LANES*DATA_WIDTH  descrambled data, same lane packing
//  out_valid  out  1                 out holds a new word
//  locked     out  LANES             lane k has received >=15 bits since reset
// BEHAVIOUR
//  - Bit order: within each lane word, bit DATA_WIDTH-1 is the earliest bit in time (n=0).
//  - Per lane: d(n) = s(n) ^ s(n-14) ^ s(n-15), where s is the scrambled input stream.
//    - The s(n-14) and s(n-15) terms come from the current word or from the lane's
//      15-bit history register.
//  - History register holds the last 15 scrambled bits received, i.e. the LSB-most 15 bits of the last accepted word.
//  - Word accepted when in_valid=1. On acceptance:
//    - history <= in[14:0] (per lane);
//    - out <= descrambled word, or in when bypass=1;
//    - out_valid <= 1.
//  - in_valid=0: history and out hold their values; out_valid <= 0.
//  - Latency: 1 clk from in/in_valid to out/out_valid (registered, no combinational path).
//  - bypass is sampled in the same cycle as in_valid.
//  - History updates in bypass mode too, so leaving bypass gives correct output on the next word.
//  - locked[k] <= 1 on the first accepted word (DATA_WIDTH>=16 covers 15 bits).
//    - It is sticky and is cleared only by reset.
//  - No backpressure: the block always accepts in_valid.
//  - Reset (asynchronous assert, any cycle including mid-stream): history=0, out=0, out_valid=0, locked=0.
//    - The first word after reset is descrambled against zero history; its leading 15 bits may be wrong by design.
//    - Downstream qualifies that word with locked.
//  - Lanes are fully independent: data on one lane never affects another.
// CONFIGURATION
//  JESD_SCR_PIPE2_EN defined: a second output register stage is added.
//    - Latency is 2 clk; out, out_valid and locked are all delayed one extra cycle together.
//    - Reset clears both stages.
//  JESD_SCR_PIPE2_EN undefined: latency is 1 clk as above.
// TESTING
//  1 Reset:
//    - Hold reset=0 with in_valid=1 and random in -> out=0, out_valid=0, locked=0 every cycle.
//  2 Impulse, LANES=1, DATA_WIDTH=32:
//    - Cycle 0 after reset: in=32'h80000000 valid -> next cycle out=32'h80030000, out_valid=1, locked=1.
//    - Cycle 1: in=0 -> following cycle out=32'h00000000.
//  3 Loopback:
//    - Drive the existing jesd204b_scrambler per lane with 32'hbeefbeef, incremented by 32'h04040404 each cycle.
//    - Feed its output into this block.
//    - From the 2nd word on, out equals the scrambler input delayed by scrambler+descrambler latency.
//    - Different seed words per lane -> no cross-lane corruption.
//  4 Gaps and bypass:
//    - Insert in_valid=0 gaps -> out holds, out_valid=0, and the stream stays correct after the gap.
//    - Assert bypass for 3 words -> out == in for those words.
//    - Deassert bypass -> the first following word is descrambled correctly.
//  5 Mid-stream reset:
//    - Pulse reset low between clock edges -> outputs clear immediately (asynchronous), without waiting for clk.
//    - locked re-asserts on the first word after release.
//  6 Build with JESD_SCR_PIPE2_EN and rerun tests 2-4 -> identical data, latency 2.

Source files
------------

// File: rtl/jesd204b_descrambler_mlane.sv
// Multi-lane JESD204B self-synchronising descrambler (1 + x^14 + x^15), one LFSR history per lane.
// Optional macro JESD_SCR_PIPE2_EN adds a second output register stage (latency 2 instead of 1).
module jesd204b_descrambler_mlane #(
   parameter int LANES      = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        bypass,
   input  logic                        in_valid,
   input  logic [LANES*DATA_WIDTH-1:0] in,
   output logic [LANES*DATA_WIDTH-1:0] out,
   output logic                        out_valid,
   output logic [LANES-1:0]            locked
);

   localparam int W  = LANES * DATA_WIDTH;
   localparam int HW = 15;

   logic [LANES*HW-1:0] hist_q, hist_d;
   logic [W-1:0]        data_q, data_d;
   logic                vld_q, vld_d;
   logic [LANES-1:0]    lock_q, lock_d;
   logic [W-1:0]        descr;

   // Bit DATA_WIDTH-1 is earliest in time, so the bits that precede in[i] sit at
   // higher indices of {history, word}; history[0] is the bit just before in[MSB].
   for (genvar k = 0; k < LANES; k++) begin : g_lane
      logic [DATA_WIDTH+HW-1:0] ext;
      assign ext = {hist_q[k*HW +: HW], in[k*DATA_WIDTH +: DATA_WIDTH]};
      for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
         assign descr[k*DATA_WIDTH + i] = ext[i] ^ ext[i+14] ^ ext[i+15];
      end
   end

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      hist_d = hist_q;
      data_d = data_q;
      vld_d  = 1'b0;
      lock_d = lock_q;
      if (in_valid) begin
         for (int k = 0; k < LANES; k++) begin
            hist_d[k*HW +: HW] = in[k*DATA_WIDTH +: HW];
         end
         data_d = bypass ? in : descr;
         vld_d  = 1'b1;
         lock_d = '1;
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hist_q <= '0;
         data_q <= '0;
         vld_q  <= 1'b0;
         lock_q <= '0;
      end else begin
         hist_q <= hist_d;
         data_q <= data_d;
         vld_q  <= vld_d;
         lock_q <= lock_d;
      end
   end

`ifdef JESD_SCR_PIPE2_EN
   logic [W-1:0]     data2_q, data2_d;
   logic             vld2_q, vld2_d;
   logic [LANES-1:0] lock2_q, lock2_d;

   always_comb begin
      data2_d = data_q;
      vld2_d  = vld_q;
      lock2_d = lock_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data2_q <= '0;
         vld2_q  <= 1'b0;
         lock2_q <= '0;
      end else begin
         data2_q <= data2_d;
         vld2_q  <= vld2_d;
         lock2_q <= lock2_d;
      end
   end

   assign out       = data2_q;
   assign out_valid = vld2_q;
   assign locked    = lock2_q;
`else
   assign out       = data_q;
   assign out_valid = vld_q;
   assign locked    = lock_q;
`endif

endmodule
